key_value_selector: RTL and testbench
=====================================

Name: key_value_selector

Overview:
- Operator-input stage feeding the two-digit 7-segment decoder on DE2-115.
- Takes two raw active-low push-buttons (up/down), synchronises and debounces them, and steps a 5-bit value with auto-repeat on hold.
- o_value drives the decoder's 5-bit binary input directly. The block also emits a one-cycle pulse on every change, for downstream consumers such as the render-parameter registers.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a key level change (10 ms at 50 MHz); legal range >= 1.
- REPEAT_DELAY, 25000000, cycles a key must stay held after its initial step before the first auto-repeat step; >= 1.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps; >= 1.
- MAX_VALUE, 31, upper bound of o_value; range 0..31.
- INIT_VALUE, 0, o_value after reset; must be <= MAX_VALUE.
- WRAP, 1, 1 = wrap at the bounds, 0 = saturate at the bounds.

Ports:
- i_clk  input  1  system clock, 50 MHz
- i_rst_n  input  1  asynchronous active-low reset
- i_key_up_n  input  1  raw increment button, active-low, asynchronous to i_clk
- i_key_dn_n  input  1  raw decrement button, active-low, asynchronous to i_clk
- o_value  output  5  current selected value, 0..MAX_VALUE, registered
- o_step  output  1  one-cycle pulse on the same edge o_value changes

Behaviour:
- Reset (async assert, sync release via i_rst_n): o_value=INIT_VALUE, o_step=0, synchronisers=1, debounced levels=1 (released), all counters=0, FSM=IDLE.
- Synchroniser: two flops per key; the second flop output is the sampled level s.
- Debounce (per key):
  - A counter increments while s != debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes s and the counter clears.
- Press event: debounced falling edge (1->0), registered.
- Latency: a raw fall first sampled on edge N gives o_value/o_step updating on edge N+2+DEBOUNCE_CYCLES+1. No other added latency.
- FSM (shared, one step source at a time):
  - IDLE:
    - Up press only -> step +1, go to DELAY (dir=up).
    - Down press only -> step -1, go to DELAY (dir=down).
    - Both pressed on the same cycle -> no step, go to BLOCKED.
  - DELAY:
    - A repeat counter counts held cycles.
    - After REPEAT_DELAY cycles with the dir key still debounced-pressed -> step, go to REPEAT, clear the counter.
  - REPEAT: step every REPEAT_PERIOD cycles while held.
  - DELAY/REPEAT exit rules:
    - Dir key released -> IDLE, no step.
    - Other key becomes pressed -> BLOCKED, no step.
  - BLOCKED: no steps; go to IDLE only when both debounced levels are released.
- Arithmetic (5-bit unsigned):
  - Up at MAX_VALUE: WRAP=1 -> 0; WRAP=0 -> hold, o_step stays 0.
  - Down at 0: WRAP=1 -> MAX_VALUE; WRAP=0 -> hold, o_step stays 0.
  - o_value never exceeds MAX_VALUE.
- o_step: asserted exactly one cycle per actual change of o_value. It is never asserted when a saturated step leaves the value unchanged.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES samples is ignored and does not restart the repeat timer.
- Reset mid-hold: all state returns to the reset values. A key still held after release is treated as a new press (one step after DEBOUNCE_CYCLES+3 edges).
- MAX_VALUE=0: o_value is constant 0, o_step never asserts.

Test Plan:
- DEBOUNCE_CYCLES=4, INIT_VALUE=0, single clean up press:
  - Raw fall sampled on edge N -> o_value=1 and o_step=1 on edge N+7.
  - o_step=0 on edge N+8.
  - Release -> no further change.
- Bounce: up key toggled with 3-cycle pulses for 40 cycles, then released -> o_value unchanged, o_step never asserted.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_PERIOD=3, down held from value 5:
  - Steps to 4, then 3 after 10 cycles.
  - Then 2, 1, 0 every 3 cycles.
  - WRAP=1 -> next step 31. WRAP=0 -> value stays 0 and o_step stays low.
- Wrap/saturate: MAX_VALUE=19, value 19, up press:
  - WRAP=1 -> 0 with an o_step pulse.
  - WRAP=0 -> 19 with no pulse.
  - The decoder then shows "00" or "19".
- Simultaneous keys: up held (value 7 -> 8), then down pressed -> no steps during overlap. Release down only -> still no steps. Release both, press up -> value 9.
- Reset mid-repeat:
  - i_rst_n low asynchronously while up is in REPEAT at value 12 -> o_value=INIT_VALUE and o_step=0 immediately, without waiting for a clock edge.
  - With up still held after release -> exactly one step after DEBOUNCE_CYCLES+3 edges, then repeat resumes per timing.

Source files
------------

// File: rtl/key_value_selector.sv
// rtl/key_value_selector.sv - debounced up/down key stepper with auto-repeat
//
// Purpose: synchronises and debounces two active-low push-buttons and steps
// a 5-bit value up or down. A held key repeats after an initial delay.
// Pressing both keys blocks stepping until both keys are released.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_key_up_n  raw increment button, active-low, asynchronous
//   i_key_dn_n  raw decrement button, active-low, asynchronous
//   o_value     current value, 0..MAX_VALUE, registered
//   o_step      one-cycle pulse on every actual change of o_value

module key_value_selector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int MAX_VALUE       = 31,
    parameter int INIT_VALUE      = 0,
    parameter int WRAP            = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_up_n,
    input  logic       i_key_dn_n,
    output logic [4:0] o_value,
    output logic       o_step
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);
    localparam logic [4:0]      MAX_V   = 5'(MAX_VALUE);
    localparam logic [4:0]      INIT_V  = 5'(INIT_VALUE);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, BLOCKED} state_t;

    // Bit 0 is the up key, bit 1 the down key; all levels active-low.
    logic [1:0]      raw_n;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      deb_q;
    logic [1:0]      deb_dly_q;
    logic [1:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [1:0]      held;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;      // 0 = up, 1 = down
    logic [RC_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [4:0]      value_q;
    logic            step_q;

    logic            step_req;
    logic            step_down;
    logic [4:0]      step_val;

    assign raw_n = {i_key_dn_n, i_key_up_n};
    assign held  = ~deb_q;

    // Synchroniser, debounce counter and registered falling-edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            deb_q       <= 2'b11;
            deb_dly_q   <= 2'b11;
            press_q     <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q   <= raw_n;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            press_q   <= deb_dly_q & ~deb_q;
            for (int k = 0; k < 2; k++) begin
                if (sync2_q[k] == deb_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    deb_q[k]    <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    // Bounded step: wrap or saturate at 0 and MAX_VALUE.
    function automatic logic [4:0] bump(input logic [4:0] v, input logic down);
        if (!down) begin
            if (v >= MAX_V) return (WRAP != 0) ? 5'd0 : MAX_V;
            return v + 5'd1;
        end
        if (v == 5'd0) return (WRAP != 0) ? MAX_V : 5'd0;
        return v - 5'd1;
    endfunction

    assign step_val = bump(value_q, step_down);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rep_cnt_d = rep_cnt_q;
        step_req  = 1'b0;
        step_down = dir_q;
        case (state_q)
            IDLE: begin
                rep_cnt_d = '0;
                if (press_q == 2'b11) begin
                    state_d = BLOCKED;
                end else if (press_q != 2'b00) begin
                    step_req  = 1'b1;
                    step_down = press_q[1];
                    dir_d     = press_q[1];
                    state_d   = DELAY;
                end
            end
            DELAY, REPEAT: begin
                // Release of the stepping key wins over a press of the other one.
                if (!held[dir_q]) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (held[~dir_q]) begin
                    state_d   = BLOCKED;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == ((state_q == DELAY) ? RD_LAST : RP_LAST)) begin
                    step_req  = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = REPEAT;
                end else begin
                    rep_cnt_d = rep_cnt_q + RC_W'(1);
                end
            end
            BLOCKED: begin
                if (held == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            rep_cnt_q <= '0;
            value_q   <= INIT_V;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rep_cnt_q <= rep_cnt_d;
            // A saturated step leaves the value alone and raises no pulse.
            step_q    <= step_req && (step_val != value_q);
            if (step_req) value_q <= step_val;
        end
    end

    assign o_value = value_q;
    assign o_step  = step_q;

endmodule

// File: tb/tb_key_value_selector.sv
// tb/tb_key_value_selector.sv - self-checking bench for key_value_selector

module tb_key_value_selector;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int NI = 5;

    function automatic int maxv(int i);
        case (i)
            0, 1:    return 31;
            2, 3:    return 19;
            default: return 0;
        endcase
    endfunction

    function automatic int wrapv(int i);
        case (i)
            1, 3:    return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int initv(int i);
        case (i)
            2, 3:    return 19;
            default: return 0;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic [4:0] dut_val  [NI];
    logic       dut_step [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        key_value_selector #(
            .DEBOUNCE_CYCLES(D),
            .REPEAT_DELAY   (RD),
            .REPEAT_PERIOD  (RP),
            .MAX_VALUE      (maxv(g)),
            .INIT_VALUE     (initv(g)),
            .WRAP           (wrapv(g))
        ) u_dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_key_up_n(key_up_n),
            .i_key_dn_n(key_dn_n),
            .o_value   (dut_val[g]),
            .o_step    (dut_step[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, int idx, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endfunction

    // Reference model: values after the most recent edge.
    int exp_val  [NI];
    bit exp_step [NI];
    bit m_sync1 [2];
    bit m_s     [2];
    bit m_deb   [2];   // debounced level after edge T-1
    bit m_deb1  [2];   // after edge T-2
    bit m_deb2  [2];   // after edge T-3
    bit hist_up [$];
    bit hist_dn [$];
    int m_mode;        // 0 idle, 1 holding a direction, 2 blocked
    int m_dir;         // 0 up, 1 down
    int m_since;       // edges since the last step of the current hold
    int m_nsteps;      // steps issued in the current hold

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_val[i]  = initv(i);
            exp_step[i] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            m_sync1[k] = 1'b1; m_s[k] = 1'b1; m_deb[k] = 1'b1;
            m_deb1[k] = 1'b1;  m_deb2[k] = 1'b1;
        end
        hist_up.delete();
        hist_dn.delete();
        m_mode = 0; m_dir = 0; m_since = 0; m_nsteps = 0;
    endtask

    task automatic apply_step(int down);
        int o, n;
        for (int i = 0; i < NI; i++) begin
            o = exp_val[i];
            if (down != 0) n = (o == 0) ? ((wrapv(i) != 0) ? maxv(i) : 0) : o - 1;
            else           n = (o >= maxv(i)) ? ((wrapv(i) != 0) ? 0 : maxv(i)) : o + 1;
            exp_val[i]  = n;
            exp_step[i] = (n != o);
        end
    endtask

    // Level is accepted once the last D visible samples all disagree with it.
    task automatic deb_update(input bit s, inout bit q[$], inout bit deb);
        bit all_diff;
        q.push_back(s);
        if (q.size() > D) void'(q.pop_front());
        all_diff = (q.size() == D);
        foreach (q[j]) if (q[j] == deb) all_diff = 1'b0;
        if (all_diff) deb = !deb;
    endtask

    task automatic model_edge();
        bit pr [2];
        bit hd [2];
        int due;
        for (int i = 0; i < NI; i++) exp_step[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pr[k] = m_deb2[k] && !m_deb1[k];
            hd[k] = !m_deb[k];
        end
        case (m_mode)
            0: begin
                if (pr[0] && pr[1]) m_mode = 2;
                else if (pr[0] || pr[1]) begin
                    m_dir = pr[0] ? 0 : 1;
                    apply_step(m_dir);
                    m_mode = 1; m_since = 0; m_nsteps = 1;
                end
            end
            1: begin
                if (!hd[m_dir]) m_mode = 0;
                else if (hd[1 - m_dir]) m_mode = 2;
                else begin
                    m_since++;
                    due = (m_nsteps == 1) ? RD : RP;
                    if (m_since == due) begin
                        apply_step(m_dir);
                        m_since = 0;
                        m_nsteps++;
                    end
                end
            end
            default: if (!hd[0] && !hd[1]) m_mode = 0;
        endcase
        for (int k = 0; k < 2; k++) begin
            m_deb2[k] = m_deb1[k];
            m_deb1[k] = m_deb[k];
        end
        deb_update(m_s[0], hist_up, m_deb[0]);
        deb_update(m_s[1], hist_dn, m_deb[1]);
        m_s[0] = m_sync1[0];
        m_s[1] = m_sync1[1];
        m_sync1[0] = key_up_n;
        m_sync1[1] = key_dn_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check("model_value", i, dut_val[i], exp_val[i]);
                check("model_step", i, dut_step[i], exp_step[i]);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_async_reset();
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int nst;

    initial begin
        cyc(3);
        check("rst_val", 0, dut_val[0], 0);
        check("rst_step", 0, dut_step[0], 0);
        check("rst_val", 2, dut_val[2], 19);
        rst_n = 1'b1;
        cyc(5);

        // Clean up press: step lands on edge N+7.
        key_up_n = 1'b0;
        cyc(7);
        check("press_n6_val", 0, dut_val[0], 0);
        cyc(1);
        check("press_n7_val", 0, dut_val[0], 1);
        check("press_n7_step", 0, dut_step[0], 1);
        check("wrap19_val", 2, dut_val[2], 0);
        check("wrap19_step", 2, dut_step[2], 1);
        check("sat19_val", 3, dut_val[3], 19);
        check("sat19_step", 3, dut_step[3], 0);
        check("max0_step", 4, dut_step[4], 0);
        cyc(1);
        check("press_n8_step", 0, dut_step[0], 0);
        key_up_n = 1'b1;
        cyc(20);
        check("release_val", 0, dut_val[0], 1);

        // Bounce: 3-cycle pulses never pass the debouncer.
        nst = 0;
        for (int i = 0; i < 40; i++) begin
            key_up_n = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
            cyc(1);
            nst += int'(dut_step[0]);
        end
        key_up_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            nst += int'(dut_step[0]);
        end
        check("bounce_steps", 0, nst, 0);
        check("bounce_val", 0, dut_val[0], 1);

        repeat (4) begin
            key_up_n = 1'b0; cyc(9);
            key_up_n = 1'b1; cyc(12);
        end
        check("preset5_val", 0, dut_val[0], 5);
        check("preset5_val", 1, dut_val[1], 5);

        // Auto-repeat down from 5.
        key_dn_n = 1'b0;
        cyc(8);  check("rep_4", 0, dut_val[0], 4);
        cyc(10); check("rep_3", 0, dut_val[0], 3);
        cyc(3);  check("rep_2", 0, dut_val[0], 2);
        cyc(3);  check("rep_1", 0, dut_val[0], 1);
        cyc(3);  check("rep_0", 0, dut_val[0], 0);
        cyc(3);
        check("rep_wrap_val", 0, dut_val[0], 31);
        check("rep_wrap_step", 0, dut_step[0], 1);
        check("rep_sat_val", 1, dut_val[1], 0);
        check("rep_sat_step", 1, dut_step[1], 0);
        key_dn_n = 1'b1;
        cyc(20);

        // Simultaneous keys.
        do_async_reset();
        cyc(3);
        key_up_n = 1'b0;
        cyc(8);
        check("both_first", 0, dut_val[0], 1);
        key_dn_n = 1'b0;
        nst = 0;
        for (int i = 0; i < 30; i++) begin cyc(1); nst += int'(dut_step[0]); end
        key_dn_n = 1'b1;
        for (int i = 0; i < 30; i++) begin cyc(1); nst += int'(dut_step[0]); end
        check("both_steps", 0, nst, 0);
        check("both_val", 0, dut_val[0], 1);
        key_up_n = 1'b1;
        cyc(15);
        key_up_n = 1'b0;
        cyc(8);
        check("both_after", 0, dut_val[0], 2);
        key_up_n = 1'b1;
        cyc(15);

        // Reset in the middle of a repeat.
        do_async_reset();
        cyc(3);
        key_up_n = 1'b0;
        cyc(8);
        cyc(40);
        check("mid_12_val", 0, dut_val[0], 12);
        check("mid_12_step", 0, dut_step[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_val", 0, dut_val[0], 0);
        check("async_step", 0, dut_step[0], 0);
        check("async_val", 2, dut_val[2], 19);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(7);
        check("rehold_n6", 0, dut_val[0], 0);
        cyc(1);
        check("rehold_val", 0, dut_val[0], 1);
        check("rehold_step", 0, dut_step[0], 1);
        cyc(10); check("rehold_rep1", 0, dut_val[0], 2);
        cyc(3);  check("rehold_rep2", 0, dut_val[0], 3);
        key_up_n = 1'b1;
        cyc(20);

        // Randomised key activity checked by the model.
        for (int it = 0; it < 160; it++) begin
            if ($urandom_range(0, 99) < 4) begin
                do_async_reset();
            end else begin
                key_up_n = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
                key_dn_n = ($urandom_range(0, 4) < 2) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 4));
                else                           cyc($urandom_range(5, 50));
            end
        end
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
